sprite_blitter: RTL and testbench

- Command-driven sprite copy engine. Reads a rectangular region of the sprite VRAM (sync ROM/RAM, 1-cycle read latency) and streams destination pixels into the framebuffer writer.
- Generalises the fixed-layer blit screens: source rectangle, destination position, horizontal flip and colour-key transparency are supplied per command instead of being hardcoded.
- Adds destination clipping, output backpressure and a done pulse.
- Sits between the game/CPU command logic and the framebuffer write port.

---
 rtl/blit_pkg.sv | 30 +++
 rtl/blit_addr_gen.sv | 77 +++++++
 rtl/sprite_blitter.sv | 180 ++++++++++++++++++
 tb/tb_sprite_blitter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/blit_pkg.sv
// Shared geometry defaults, FSM state encoding and command record for the sprite blitter.
package blit_pkg;

   localparam int DEF_SRC_W      = 160;
   localparam int DEF_SRC_H      = 350;
   localparam int DEF_DST_W      = 160;
   localparam int DEF_DST_H      = 120;
   localparam int DEF_COLOR_BITS = 9;
   localparam int DEF_ADDRW      = 16;
   localparam int DEF_COORDW     = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } blit_state_e;

   typedef struct packed {
      logic [DEF_COORDW-1:0] src_x;
      logic [DEF_COORDW-1:0] src_y;
      logic [DEF_COORDW-1:0] w;
      logic [DEF_COORDW-1:0] h;
      logic [DEF_COORDW-1:0] dst_x;
      logic [DEF_COORDW-1:0] dst_y;
      logic                  flip_x;
      logic                  key_en;
   } blit_cmd_t;

endpackage

// File: rtl/blit_addr_gen.sv
// Row-major walker over the source rectangle: produces the registered VRAM address (S0)
// together with the destination coordinates of the pixel it fetches.
module blit_addr_gen import blit_pkg::*; #(
   parameter int SRC_W  = DEF_SRC_W,
   parameter int ADDRW  = DEF_ADDRW,
   parameter int COORDW = DEF_COORDW
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              advance,
   input  logic              issue,
   input  logic [COORDW-1:0] src_x,
   input  logic [COORDW-1:0] src_y,
   input  logic [COORDW-1:0] w,
   input  logic [COORDW-1:0] h,
   input  logic [COORDW-1:0] dst_x,
   input  logic [COORDW-1:0] dst_y,
   input  logic              flip_x,
   output logic [ADDRW-1:0]  vram_addr,
   output logic              tag_valid,
   output logic [COORDW:0]   dx,
   output logic [COORDW:0]   dy,
   output logic              last
);

   logic [COORDW-1:0] i_r;
   logic [COORDW-1:0] j_r;
   logic [ADDRW-1:0]  sx_s;
   logic [ADDRW-1:0]  sy_s;
   logic [ADDRW-1:0]  addr_s;
   logic              row_end_s;

   // Source column/row mapping and address multiply-add; sums wrap modulo 2^ADDRW.
   always_comb begin
      sx_s = ADDRW'(src_x) + ADDRW'(i_r);
      if (flip_x) begin
         sx_s = ADDRW'(src_x) + ADDRW'(w) - ADDRW'(i_r) - ADDRW'(1'b1);
      end else begin
         sx_s = ADDRW'(src_x) + ADDRW'(i_r);
      end
      sy_s      = ADDRW'(src_y) + ADDRW'(j_r);
      addr_s    = sy_s * ADDRW'(SRC_W) + sx_s;
      row_end_s = (i_r == w - COORDW'(1'b1));
      last      = row_end_s && (j_r == h - COORDW'(1'b1));
   end

   // Counters and the S0 address/tag register; everything holds while the output stalls.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         i_r       <= {COORDW{1'b0}};
         j_r       <= {COORDW{1'b0}};
         vram_addr <= {ADDRW{1'b0}};
         tag_valid <= 1'b0;
         dx        <= {(COORDW+1){1'b0}};
         dy        <= {(COORDW+1){1'b0}};
      end else if (clear) begin
         i_r       <= {COORDW{1'b0}};
         j_r       <= {COORDW{1'b0}};
         tag_valid <= 1'b0;
      end else if (advance) begin
         tag_valid <= issue;
         if (issue) begin
            vram_addr <= addr_s;
            dx        <= {1'b0, dst_x} + {1'b0, i_r};
            dy        <= {1'b0, dst_y} + {1'b0, j_r};
            if (row_end_s) begin
               i_r <= {COORDW{1'b0}};
               j_r <= j_r + COORDW'(1'b1);
            end else begin
               i_r <= i_r + COORDW'(1'b1);
            end
         end
      end
   end

endmodule

// File: rtl/sprite_blitter.sv
// Command-driven sprite copy engine: VRAM read pipeline with clipping, colour-key
// filtering and a stall-able output register feeding the framebuffer writer.
module sprite_blitter import blit_pkg::*; #(
   parameter int SRC_W      = DEF_SRC_W,
   parameter int SRC_H      = DEF_SRC_H,
   parameter int DST_W      = DEF_DST_W,
   parameter int DST_H      = DEF_DST_H,
   parameter int COLOR_BITS = DEF_COLOR_BITS,
   parameter int ADDRW      = DEF_ADDRW,
   parameter int COORDW     = DEF_COORDW,
   parameter logic [COLOR_BITS-1:0] KEY_COLOR = {COLOR_BITS{1'b1}}
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [COORDW-1:0]     cmd_src_x,
   input  logic [COORDW-1:0]     cmd_src_y,
   input  logic [COORDW-1:0]     cmd_w,
   input  logic [COORDW-1:0]     cmd_h,
   input  logic [COORDW-1:0]     cmd_dst_x,
   input  logic [COORDW-1:0]     cmd_dst_y,
   input  logic                  cmd_flip_x,
   input  logic                  cmd_key_en,
   output logic [ADDRW-1:0]      vram_addr,
   input  logic [COLOR_BITS-1:0] vram_q,
   output logic                  pix_valid,
   input  logic                  pix_ready,
   output logic [COORDW-1:0]     pix_x,
   output logic [COORDW-1:0]     pix_y,
   output logic [COLOR_BITS-1:0] pix_color,
   output logic                  busy,
   output logic                  done
);

   // A sprite sheet that cannot be addressed in full is a build configuration error.
   if (SRC_W * SRC_H > (1 << ADDRW)) begin : g_vram_too_big
      $error("sprite_blitter: SRC_W*SRC_H exceeds the VRAM address space");
   end

   blit_state_e               state_r, state_s;
   blit_cmd_t                 cmd_r;
   logic                      accept_s, stall_s, advance_s, issue_s, last_s;
   logic                      s0_valid_s;
   logic [COORDW:0]           s0_dx_s, s0_dy_s;
   logic                      s1_valid_r, s1_loaded_r;
   logic [COORDW:0]           s1_dx_r, s1_dy_r;
   logic [COLOR_BITS-1:0]     s1_color_r, s1_color_s;
   logic                      keep_s;

   blit_addr_gen #(.SRC_W(SRC_W), .ADDRW(ADDRW), .COORDW(COORDW)) u_addr_gen (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (accept_s),
      .advance   (advance_s),
      .issue     (issue_s),
      .src_x     (COORDW'(cmd_r.src_x)),
      .src_y     (COORDW'(cmd_r.src_y)),
      .w         (COORDW'(cmd_r.w)),
      .h         (COORDW'(cmd_r.h)),
      .dst_x     (COORDW'(cmd_r.dst_x)),
      .dst_y     (COORDW'(cmd_r.dst_y)),
      .flip_x    (cmd_r.flip_x),
      .vram_addr (vram_addr),
      .tag_valid (s0_valid_s),
      .dx        (s0_dx_s),
      .dy        (s0_dy_s),
      .last      (last_s)
   );

   // Handshake and pipeline-advance decode.
   always_comb begin
      accept_s  = cmd_valid && cmd_ready;
      stall_s   = pix_valid && !pix_ready;
      advance_s = !stall_s;
      issue_s   = (state_r == RUN) && advance_s;
   end

   // Next-state logic; DRAIN leaves as soon as the last pixel is being accepted.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if ((cmd_w == {COORDW{1'b0}}) || (cmd_h == {COORDW{1'b0}})) begin
                  state_s = DONE;
               end else begin
                  state_s = RUN;
               end
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (issue_s && last_s) begin
               state_s = DRAIN;
            end else begin
               state_s = RUN;
            end
         end
         DRAIN: begin
            if (!s0_valid_s && !s1_valid_r && (!pix_valid || pix_ready)) begin
               state_s = DONE;
            end else begin
               state_s = DRAIN;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register, registered status outputs and command latch.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= IDLE;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         cmd_r     <= '0;
      end else begin
         state_r   <= state_s;
         cmd_ready <= (state_s == IDLE);
         busy      <= (state_s == RUN) || (state_s == DRAIN);
         done      <= (state_s == DONE);
         if (accept_s) begin
            cmd_r <= '{src_x: DEF_COORDW'(cmd_src_x), src_y: DEF_COORDW'(cmd_src_y),
                       w: DEF_COORDW'(cmd_w), h: DEF_COORDW'(cmd_h),
                       dst_x: DEF_COORDW'(cmd_dst_x), dst_y: DEF_COORDW'(cmd_dst_y),
                       flip_x: cmd_flip_x, key_en: cmd_key_en};
         end
      end
   end

   // After the first held cycle the VRAM shows the next address, so S1 keeps its own copy.
   always_comb begin
      s1_color_s = s1_loaded_r ? vram_q : s1_color_r;
      keep_s     = s1_valid_r
                && (s1_dx_r < (COORDW+1)'(DST_W))
                && (s1_dy_r < (COORDW+1)'(DST_H))
                && !(cmd_r.key_en && (s1_color_s == KEY_COLOR));
   end

   // S1: tag aligned with the VRAM read data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_r  <= 1'b0;
         s1_loaded_r <= 1'b0;
         s1_dx_r     <= {(COORDW+1){1'b0}};
         s1_dy_r     <= {(COORDW+1){1'b0}};
         s1_color_r  <= {COLOR_BITS{1'b0}};
      end else begin
         s1_color_r  <= s1_color_s;
         s1_loaded_r <= advance_s;
         if (advance_s) begin
            s1_valid_r <= s0_valid_s;
            s1_dx_r    <= s0_dx_s;
            s1_dy_r    <= s0_dy_s;
         end
      end
   end

   // S2: output register, frozen while the sink refuses the pixel.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pix_valid <= 1'b0;
         pix_x     <= {COORDW{1'b0}};
         pix_y     <= {COORDW{1'b0}};
         pix_color <= {COLOR_BITS{1'b0}};
      end else if (advance_s) begin
         pix_valid <= keep_s;
         if (keep_s) begin
            pix_x     <= s1_dx_r[COORDW-1:0];
            pix_y     <= s1_dy_r[COORDW-1:0];
            pix_color <= s1_color_s;
         end
      end
   end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed self-checking bench for sprite_blitter with a behavioural 1-cycle-latency VRAM.
module tb_sprite_blitter;

   localparam int CB = 9;
   localparam int AW = 16;
   localparam int CW = 10;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          cmd_valid, cmd_ready;
   logic [CW-1:0] cmd_src_x, cmd_src_y, cmd_w, cmd_h, cmd_dst_x, cmd_dst_y;
   logic          cmd_flip_x, cmd_key_en;
   logic [AW-1:0] vram_addr;
   logic [CB-1:0] vram_q;
   logic          pix_valid, pix_ready;
   logic [CW-1:0] pix_x, pix_y;
   logic [CB-1:0] pix_color;
   logic          busy, done;

   logic [CB-1:0] vram [0:65535];

   int total = 0;
   int bad   = 0;

   int addr_log[$], pv_log[$], x_log[$], y_log[$], c_log[$], rdy_log[$];
   int acc_x[$], acc_y[$], acc_c[$];
   int exp_x[$], exp_y[$], exp_c[$];
   int first_pix_k, done_k, done_cnt;

   sprite_blitter dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_src_x(cmd_src_x), .cmd_src_y(cmd_src_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
      .cmd_dst_x(cmd_dst_x), .cmd_dst_y(cmd_dst_y),
      .cmd_flip_x(cmd_flip_x), .cmd_key_en(cmd_key_en),
      .vram_addr(vram_addr), .vram_q(vram_q),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) vram_q <= vram[vram_addr];

   function automatic logic [CB-1:0] cval(input int a);
      logic [31:0] t;
      t = a;
      return {1'b0, t[7:0]} ^ 9'h055;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic expect_pix(input int x, input int y, input int c);
      exp_x.push_back(x);
      exp_y.push_back(y);
      exp_c.push_back(c);
   endtask

   task automatic compare_pix(input string tag);
      check_eq({tag, "_npix"}, acc_x.size(), exp_x.size());
      for (int i = 0; i < exp_x.size() && i < acc_x.size(); i++) begin
         check_eq($sformatf("%s_x%0d", tag, i), acc_x[i], exp_x[i]);
         check_eq($sformatf("%s_y%0d", tag, i), acc_y[i], exp_y[i]);
         check_eq($sformatf("%s_c%0d", tag, i), acc_c[i], exp_c[i]);
      end
      exp_x.delete(); exp_y.delete(); exp_c.delete();
   endtask

   // Issue one command and log every cycle from the one after acceptance (k=0).
   task automatic run_cmd(input string tag, input int sx, input int sy, input int w, input int h,
                          input int dx, input int dy, input bit flip, input bit key,
                          input int stall_len);
      addr_log.delete(); pv_log.delete(); x_log.delete(); y_log.delete();
      c_log.delete(); rdy_log.delete(); acc_x.delete(); acc_y.delete(); acc_c.delete();
      first_pix_k = -1; done_k = -1; done_cnt = 0;
      @(negedge clk);
      cmd_src_x = CW'(sx); cmd_src_y = CW'(sy); cmd_w = CW'(w); cmd_h = CW'(h);
      cmd_dst_x = CW'(dx); cmd_dst_y = CW'(dy); cmd_flip_x = flip; cmd_key_en = key;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int k = 0; k < 300; k++) begin
         if (stall_len > 0 && first_pix_k >= 0 && k > first_pix_k && k <= first_pix_k + stall_len)
            pix_ready = 1'b0;
         else
            pix_ready = 1'b1;
         addr_log.push_back(vram_addr);
         pv_log.push_back(pix_valid);
         x_log.push_back(pix_x);
         y_log.push_back(pix_y);
         c_log.push_back(pix_color);
         rdy_log.push_back(cmd_ready);
         if (pix_valid && first_pix_k < 0) first_pix_k = k;
         if (pix_valid && pix_ready) begin
            acc_x.push_back(pix_x);
            acc_y.push_back(pix_y);
            acc_c.push_back(pix_color);
         end
         if (done) begin
            done_cnt++;
            if (done_k < 0) done_k = k;
         end
         if (done_k >= 0 && k >= done_k + 1) break;
         @(negedge clk);
      end
      pix_ready = 1'b1;
      check_eq({tag, "_done_seen"}, done_k >= 0, 1);
      check_eq({tag, "_done_once"}, done_cnt, 1);
   endtask

   initial begin
      int dcount, pvcount;
      reset_n = 1'b0; cmd_valid = 1'b0; pix_ready = 1'b1;
      cmd_src_x = '0; cmd_src_y = '0; cmd_w = '0; cmd_h = '0;
      cmd_dst_x = '0; cmd_dst_y = '0; cmd_flip_x = 1'b0; cmd_key_en = 1'b0;
      for (int a = 0; a < 65536; a++) vram[a] = cval(a);
      vram[1601] = 9'h1FF;

      repeat (2) @(negedge clk);
      check_eq("rst_cmd_ready", cmd_ready, 1);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_pix_valid", pix_valid, 0);
      check_eq("rst_vram_addr", vram_addr, 0);
      reset_n = 1'b1;
      @(negedge clk);
      check_eq("post_rst_cmd_ready", cmd_ready, 1);

      // 2x2 copy
      run_cmd("t1", 0, 0, 2, 2, 10, 20, 1'b0, 1'b0, 0);
      check_eq("t1_busy_ready", rdy_log[0], 0);
      check_eq("t1_addr0", addr_log[1], 0);
      check_eq("t1_addr1", addr_log[2], 1);
      check_eq("t1_addr2", addr_log[3], 160);
      check_eq("t1_addr3", addr_log[4], 161);
      check_eq("t1_latency", first_pix_k, 3);
      check_eq("t1_done_k", done_k, 7);
      check_eq("t1_ready_back", rdy_log[done_k + 1], 1);
      expect_pix(10, 20, cval(0)); expect_pix(11, 20, cval(1));
      expect_pix(10, 21, cval(160)); expect_pix(11, 21, cval(161));
      compare_pix("t1");

      // horizontal flip
      run_cmd("t2", 40, 240, 3, 1, 5, 6, 1'b1, 1'b0, 0);
      check_eq("t2_addr0", addr_log[1], 38442);
      check_eq("t2_addr1", addr_log[2], 38441);
      check_eq("t2_addr2", addr_log[3], 38440);
      expect_pix(5, 6, cval(38442)); expect_pix(6, 6, cval(38441)); expect_pix(7, 6, cval(38440));
      compare_pix("t2");

      // colour key on, then off
      run_cmd("t3a", 0, 10, 3, 1, 30, 40, 1'b0, 1'b1, 0);
      expect_pix(30, 40, cval(1600)); expect_pix(32, 40, cval(1602));
      compare_pix("t3a");
      run_cmd("t3b", 0, 10, 3, 1, 30, 40, 1'b0, 1'b0, 0);
      expect_pix(30, 40, cval(1600)); expect_pix(31, 40, 511); expect_pix(32, 40, cval(1602));
      compare_pix("t3b");

      // clipping at the framebuffer corner
      run_cmd("t4", 0, 0, 4, 2, 158, 119, 1'b0, 1'b0, 0);
      expect_pix(158, 119, cval(0)); expect_pix(159, 119, cval(1));
      compare_pix("t4");

      // backpressure: pix_ready low for 5 cycles after the first pixel
      run_cmd("t5", 0, 2, 3, 2, 50, 60, 1'b0, 1'b0, 5);
      check_eq("t5_first_pix", first_pix_k, 3);
      for (int k = 4; k <= 8; k++) begin
         check_eq($sformatf("t5_hold_v%0d", k), pv_log[k], 1);
         check_eq($sformatf("t5_hold_x%0d", k), x_log[k], 51);
         check_eq($sformatf("t5_hold_y%0d", k), y_log[k], 60);
         check_eq($sformatf("t5_hold_c%0d", k), c_log[k], cval(321));
         check_eq($sformatf("t5_hold_a%0d", k), addr_log[k], 480);
      end
      expect_pix(50, 60, cval(320)); expect_pix(51, 60, cval(321)); expect_pix(52, 60, cval(322));
      expect_pix(50, 61, cval(480)); expect_pix(51, 61, cval(481)); expect_pix(52, 61, cval(482));
      compare_pix("t5");

      // zero-width command
      run_cmd("t6", 0, 0, 0, 3, 0, 0, 1'b0, 1'b0, 0);
      check_eq("t6_done_k", done_k, 0);
      check_eq("t6_ready_low", rdy_log[0], 0);
      check_eq("t6_ready_back", rdy_log[1], 1);
      compare_pix("t6");

      // reset asserted mid-RUN
      @(negedge clk);
      cmd_src_x = '0; cmd_src_y = '0; cmd_w = CW'(8); cmd_h = CW'(4);
      cmd_dst_x = '0; cmd_dst_y = '0; cmd_flip_x = 1'b0; cmd_key_en = 1'b0;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("t7_busy_before", busy, 1);
      check_eq("t7_pix_before", pix_valid, 1);
      reset_n = 1'b0;
      #1;
      check_eq("t7_cmd_ready", cmd_ready, 1);
      check_eq("t7_busy", busy, 0);
      check_eq("t7_pix_valid", pix_valid, 0);
      check_eq("t7_pix_x", pix_x, 0);
      check_eq("t7_vram_addr", vram_addr, 0);
      check_eq("t7_done", done, 0);
      @(negedge clk);
      reset_n = 1'b1;
      dcount = 0; pvcount = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (done) dcount++;
         if (pix_valid) pvcount++;
      end
      check_eq("t7_no_done", dcount, 0);
      check_eq("t7_no_pix", pvcount, 0);

      // recovery after the abort
      run_cmd("t8", 0, 0, 1, 1, 3, 4, 1'b0, 1'b0, 0);
      expect_pix(3, 4, cval(0));
      compare_pix("t8");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
